ram_sync: RTL and testbench



---
 rtl/ram_sync.sv | 176 +++++++++++++++++
 tb/tb_ram_sync.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync.sv
// Dual-port RAM with registered reads, byte-lane write masks, out-of-range flags and a post-reset clear sweep.
// Optional macro RAM_FWD_EN: forward port-2 write data to a same-cycle port-1 read of the same word.
module ram_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    ready,
  input  logic [ADDR_WIDTH-1:0]   a1,
  input  logic                    re1,
  output logic [DATA_WIDTH-1:0]   do1,
  output logic                    v1,
  output logic                    err1,
  input  logic [ADDR_WIDTH-1:0]   a2,
  input  logic                    re2,
  input  logic                    we2,
  input  logic [DATA_WIDTH/8-1:0] m2,
  input  logic [DATA_WIDTH-1:0]   di2,
  output logic [DATA_WIDTH-1:0]   do2,
  output logic                    v2,
  output logic                    err2
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int IDX_LSB = $clog2(BYTES);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Any address bit above the word index makes the request out of range.
  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return |(a >> (IDX_LSB + IDX_W));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_LSB +: IDX_W];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [BYTES-1:0]      mask);
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < BYTES; i++) begin
      if (mask[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  state_t                state_r;
  logic [IDX_W-1:0]      clr_cnt_r;
  logic [IDX_W-1:0]      idx1_s;
  logic [IDX_W-1:0]      idx2_s;
  logic                  oor1_s;
  logic                  oor2_s;
  logic                  acc1_s;
  logic                  acc2_s;
  logic                  wr2_s;
  logic [DATA_WIDTH-1:0] rd1_word_s;

  assign idx1_s = word_idx(a1);
  assign idx2_s = word_idx(a2);
  assign oor1_s = out_of_range(a1);
  assign oor2_s = out_of_range(a2);
  assign acc1_s = (state_r == ST_RUN) && re1;
  assign acc2_s = (state_r == ST_RUN) && (re2 || we2);
  assign wr2_s  = acc2_s && we2 && !oor2_s && !reset;

  // Port-1 read word, optionally merged with a same-cycle port-2 write.
  always_comb begin
    rd1_word_s = mem_r[idx1_s];
`ifdef RAM_FWD_EN
    if (we2 && !oor2_s && (idx1_s == idx2_s)) begin
      rd1_word_s = merge_lanes(mem_r[idx1_s], di2, m2);
    end else begin
      rd1_word_s = mem_r[idx1_s];
    end
`endif
  end

  // Storage: zero sweep while clearing, masked lane writes from port 2 while running.
  always_ff @(posedge clk) begin
    if ((state_r == ST_CLEAR) && !reset) begin
      mem_r[clr_cnt_r] <= {DATA_WIDTH{1'b0}};
    end else if (wr2_s) begin
      for (int i = 0; i < BYTES; i++) begin
        if (m2[i]) begin
          mem_r[idx2_s][8*i +: 8] <= di2[8*i +: 8];
        end
      end
    end
  end

  // Clear/run sequencing; ready rises on the edge that zeroes the last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_CLEAR;
      clr_cnt_r <= {IDX_W{1'b0}};
      ready     <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clr_cnt_r <= clr_cnt_r + IDX_W'(1);
          if (clr_cnt_r == LAST_IDX) begin
            state_r <= ST_RUN;
            ready   <= 1'b1;
          end
        end
        ST_RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_cnt_r <= {IDX_W{1'b0}};
          ready     <= 1'b0;
        end
      endcase
    end
  end

  // Port-1 response register; data holds when no request is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      do1  <= {DATA_WIDTH{1'b0}};
      v1   <= 1'b0;
      err1 <= 1'b0;
    end else if (acc1_s) begin
      v1 <= 1'b1;
      if (oor1_s) begin
        err1 <= 1'b1;
        do1  <= {DATA_WIDTH{1'b0}};
      end else begin
        err1 <= 1'b0;
        do1  <= rd1_word_s;
      end
    end else begin
      v1   <= 1'b0;
      err1 <= 1'b0;
    end
  end

  // Port-2 response register; reads are read-first against a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      do2  <= {DATA_WIDTH{1'b0}};
      v2   <= 1'b0;
      err2 <= 1'b0;
    end else if (acc2_s) begin
      v2 <= 1'b1;
      if (oor2_s) begin
        err2 <= 1'b1;
        do2  <= {DATA_WIDTH{1'b0}};
      end else if (re2) begin
        err2 <= 1'b0;
        do2  <= mem_r[idx2_s];
      end else begin
        err2 <= 1'b0;
      end
    end else begin
      v2   <= 1'b0;
      err2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_sync.sv
// Self-checking bench for ram_sync (DEPTH=16): vector table through a response scoreboard plus reset/clear sequences.
module tb_ram_sync;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 32;

  logic          clk;
  logic          reset;
  logic          ready;
  logic [AW-1:0] a1;
  logic          re1;
  logic [DW-1:0] do1;
  logic          v1;
  logic          err1;
  logic [AW-1:0] a2;
  logic          re2;
  logic          we2;
  logic [3:0]    m2;
  logic [DW-1:0] di2;
  logic [DW-1:0] do2;
  logic          v2;
  logic          err2;

  ram_sync #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .a1(a1), .re1(re1), .do1(do1), .v1(v1), .err1(err1),
    .a2(a2), .re2(re2), .we2(we2), .m2(m2), .di2(di2),
    .do2(do2), .v2(v2), .err2(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          re1;
    logic [AW-1:0] a1;
    logic          re2;
    logic          we2;
    logic [AW-1:0] a2;
    logic [3:0]    m2;
    logic [DW-1:0] di2;
    logic [DW-1:0] e_do1;
    logic          e_err1;
    logic [DW-1:0] e_do2;
    logic          e_err2;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          err;
    logic          upd;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  logic [DW-1:0] exp_do1;
  logic [DW-1:0] exp_do2;
  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[18];
  logic [DW-1:0] coll_exp;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r1, input logic [AW-1:0] ad1, input logic r2, input logic w2,
                              input logic [AW-1:0] ad2, input logic [3:0] msk, input logic [DW-1:0] d2,
                              input logic [DW-1:0] e1, input logic x1, input logic [DW-1:0] e2, input logic x2);
    vec_t v;
    v.re1 = r1; v.a1 = ad1; v.re2 = r2; v.we2 = w2; v.a2 = ad2; v.m2 = msk; v.di2 = d2;
    v.e_do1 = e1; v.e_err1 = x1; v.e_do2 = e2; v.e_err2 = x2;
    return v;
  endfunction

  task automatic check_outputs();
    exp_t e;
    chk("v1", {31'd0, v1}, {31'd0, (q1.size() != 0)});
    if (v1 && q1.size() != 0) begin
      e = q1.pop_front();
      chk("err1", {31'd0, err1}, {31'd0, e.err});
      if (e.upd) exp_do1 = e.d;
    end
    chk("do1", do1, exp_do1);
    chk("v2", {31'd0, v2}, {31'd0, (q2.size() != 0)});
    if (v2 && q2.size() != 0) begin
      e = q2.pop_front();
      chk("err2", {31'd0, err2}, {31'd0, e.err});
      if (e.upd) exp_do2 = e.d;
    end
    chk("do2", do2, exp_do2);
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    re1 = v.re1; a1 = v.a1; re2 = v.re2; we2 = v.we2; a2 = v.a2; m2 = v.m2; di2 = v.di2;
    if (v.re1) begin
      e.d = v.e_do1; e.err = v.e_err1; e.upd = 1'b1;
      q1.push_back(e);
    end
    if (v.re2 || v.we2) begin
      e.d = v.e_err2 ? 32'h0 : v.e_do2; e.err = v.e_err2; e.upd = v.re2 | v.e_err2;
      q2.push_back(e);
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic idle();
    re1 = 1'b0; a1 = 32'h0; re2 = 1'b0; we2 = 1'b0; a2 = 32'h0; m2 = 4'h0; di2 = 32'h0;
  endtask

  // Counts edges until ready rises, bounded; no response may appear meanwhile.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
      chk("clear_no_v", {30'd0, v1, v2}, 32'd0);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idle();
    exp_do1 = 32'h0;
    exp_do2 = 32'h0;
`ifdef RAM_FWD_EN
    coll_exp = 32'h0000_5678;
`else
    coll_exp = 32'h0000_0000;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_do1", do1, 32'h0);
    chk("rst_do2", do2, 32'h0);
    chk("rst_v_err", {28'd0, v1, err1, v2, err2}, 32'd0);

    // Release with requests pending during CLEAR; they must be ignored
    reset = 1'b0;
    re1 = 1'b1; re2 = 1'b1; we2 = 1'b1; a2 = 32'h0; m2 = 4'hF; di2 = 32'hFFFF_FFFF;
    wait_ready(n);
    idle();
    chk("clear_len", n, 32'd16);

    // Every word reads zero after the sweep
    for (int w = 0; w < DEPTH; w++) begin
      step(mk(1'b1, 32'(w * 4), 1'b1, 1'b0, 32'(w * 4), 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
    end

    tbl[0]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0, 1'b0);
    tbl[1]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 4'h5, 32'h11223344, 32'h0, 1'b0, 32'h0, 1'b0);
    tbl[2]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 32'h0, 1'b0, 32'hDE22BE44, 1'b0);
    tbl[3]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 4'hF, 32'hAAAAAAAA, 32'h0, 1'b0, 32'h0, 1'b0);
    tbl[4]  = mk(1'b1, 32'h8, 1'b1, 1'b1, 32'h4, 4'hF, 32'h55555555, 32'hDE22BE44, 1'b0, 32'hAAAAAAAA, 1'b0);
    tbl[5]  = mk(1'b1, 32'h4, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 32'h55555555, 1'b0, 32'h55555555, 1'b0);
    tbl[6]  = mk(1'b1, 32'h10, 1'b0, 1'b1, 32'h10, 4'h3, 32'h12345678, coll_exp, 1'b0, 32'h0, 1'b0);
    tbl[7]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 32'h0, 1'b0, 32'h00005678, 1'b0);
    tbl[8]  = mk(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
    tbl[9]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0, 1'b1);
    tbl[10] = mk(1'b1, 32'h3C, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    tbl[11] = mk(1'b1, 32'h40, 1'b1, 1'b0, 32'h9, 4'h0, 32'h0, 32'h0, 1'b1, 32'hDE22BE44, 1'b0);
    tbl[12] = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h3C, 4'h8, 32'hA5000000, 32'h0, 1'b0, 32'h0, 1'b0);
    tbl[13] = mk(1'b1, 32'h3F, 1'b1, 1'b0, 32'h3C, 4'h0, 32'h0, 32'hA5000000, 1'b0, 32'hA5000000, 1'b0);
    tbl[14] = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    tbl[15] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 32'h0, 1'b0, 32'hDE22BE44, 1'b0);
    tbl[16] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    tbl[17] = mk(1'b1, 32'h80000000, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 32'h0, 1'b1, 32'h55555555, 1'b0);
    for (int i = 0; i < 18; i++) begin
      step(tbl[i]);
    end
    idle();
    step(tbl[16]);

    // Reset in RUN with requests present: no response pulse
    reset = 1'b1;
    re1 = 1'b1; a1 = 32'h8; re2 = 1'b1; a2 = 32'h8;
    @(posedge clk); #1;
    idle();
    chk("rstrun_v", {30'd0, v1, v2}, 32'd0);
    chk("rstrun_ready", {31'd0, ready}, 32'd0);
    chk("rstrun_do", do1 | do2, 32'h0);
    exp_do1 = 32'h0;
    exp_do2 = 32'h0;

    // Reset again at clear count 7: the sweep restarts from word 0
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_ready", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_ready(n);
    chk("reclear_len", n, 32'd16);
    step(mk(1'b1, 32'h3C, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
    idle();
    step(tbl[16]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
